uart_tx: RTL and testbench

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_baud_gen.sv | 32 +++
 rtl/uart_tx.sv | 108 ++++++++++
 tb/tb_uart_tx.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter: FSM state encoding and bit-period math.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    DONE
  } state_t;

  function automatic int calc_clks_per_bit(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while running and flags the last clock of each bit.
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 10416
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic run,
  output logic bit_tick
);

  localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt;

  // Held at zero outside a frame so every frame starts on a fresh bit period.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clear || !run) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign bit_tick = run && (cnt == LAST);

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter: frame FSM and shift register, with registered tx/busy/done outputs.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 100_000_000,
  parameter int BAUD_RATE = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_in,
  input  logic       tx_en,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  localparam int CLKS_PER_BIT = calc_clks_per_bit(CLK_FREQ, BAUD_RATE);

  state_t     state;
  state_t     state_nxt;
  logic [7:0] shift;
  logic [2:0] idx;
  logic       bit_tick;
  logic       accept;
  logic       run;
  logic       tx_c;
  logic       busy_c;
  logic       done_c;

  assign accept = (state == IDLE) && tx_en;
  assign run    = (state == START) || (state == DATA) || (state == STOP);

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_gen (
    .clk     (clk),
    .rst     (rst),
    .clear   (accept),
    .run     (run),
    .bit_tick(bit_tick)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    tx_c      = 1'b1;
    busy_c    = 1'b1;
    done_c    = 1'b0;
    unique case (state)
      IDLE: begin
        busy_c = 1'b0;
        if (tx_en) state_nxt = START;
      end
      START: begin
        tx_c = 1'b0;
        if (bit_tick) state_nxt = DATA;
      end
      DATA: begin
        tx_c = shift[0];
        if (bit_tick && (idx == 3'd7)) state_nxt = STOP;
      end
      STOP: begin
        if (bit_tick) state_nxt = DONE;
      end
      DONE: begin
        done_c    = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      shift <= '0;
      idx   <= '0;
    end else if (accept) begin
      shift <= data_in;
      idx   <= '0;
    end else if ((state == DATA) && bit_tick) begin
      shift <= {1'b0, shift[7:1]};
      idx   <= idx + 3'd1;
    end
  end

  // Outputs are the state decode delayed one clock, so tx falls one edge after acceptance.
  always_ff @(posedge clk) begin
    if (!rst) begin
      tx   <= 1'b1;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      tx   <= tx_c;
      busy <= busy_c;
      done <= done_c;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Randomized self-checking bench for uart_tx using a frame-level reference model.
module tb_uart_tx;

  localparam int CLK_FREQ  = 100_000_000;
  localparam int BAUD_RATE = 6_250_000;
  localparam int CPB       = CLK_FREQ / BAUD_RATE;

  logic       clk;
  logic       rst;
  logic [7:0] data_in;
  logic       tx_en;
  logic       tx;
  logic       busy;
  logic       done;

  int checks;
  int errors;
  int done_pulses;
  int exp_done;

  uart_tx #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD_RATE(BAUD_RATE)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .data_in(data_in),
    .tx_en  (tx_en),
    .tx     (tx),
    .busy   (busy),
    .done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (done === 1'b1) done_pulses++;
  end

  task automatic send(input logic [7:0] b);
    data_in = b;
    tx_en   = 1'b1;
    @(negedge clk);
    tx_en   = 1'b0;
    data_in = 8'($urandom);
  endtask

  // Expected line: start 0, data LSB first, stop 1, each CPB clocks, then one done clock.
  task automatic check_frame(input logic [7:0] b, input string name);
    logic [9:0] frame_bits;
    int waited;
    frame_bits = {1'b1, b, 1'b0};
    waited = 0;
    while (tx !== 1'b0 && waited < 4 * CPB) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if (tx !== 1'b0) begin
      errors++;
      $display("FAIL %s start: tx=%b required 0 within %0d cycles", name, tx, 4 * CPB);
      return;
    end
    checks++;
    if (waited != 1) begin
      errors++;
      $display("FAIL %s latency: start bit after %0d cycles, required 1", name, waited);
    end
    for (int i = 0; i < 10; i++) begin
      for (int c = 0; c < CPB; c++) begin
        if (c == 0 || c == CPB / 2 || c == CPB - 1) begin
          checks++;
          if (tx !== frame_bits[i] || busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL %s bit%0d cyc%0d: tx=%b busy=%b done=%b required tx=%b busy=1 done=0",
                     name, i, c, tx, busy, done, frame_bits[i]);
          end
        end
        @(negedge clk);
      end
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b1 || tx !== 1'b1) begin
      errors++;
      $display("FAIL %s done: tx=%b busy=%b done=%b required 1 1 1", name, tx, busy, done);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || tx !== 1'b1) begin
      errors++;
      $display("FAIL %s after: tx=%b busy=%b done=%b required 1 0 0", name, tx, busy, done);
    end
  endtask

  task automatic check_idle(input int cycles, input string name);
    int bad;
    bad = 0;
    for (int c = 0; c < cycles; c++) begin
      if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) bad++;
      @(negedge clk);
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL %s idle: %0d non-idle cycles, required 0", name, bad);
    end
  endtask

  task automatic check_done_count(input string name);
    checks++;
    if (done_pulses != exp_done) begin
      errors++;
      $display("FAIL %s done count: %0d required %0d", name, done_pulses, exp_done);
    end
  endtask

  task automatic test_reset();
    rst     = 1'b0;
    tx_en   = 1'b1;
    data_in = 8'h5A;
    repeat (2) @(negedge clk);
    checks++;
    if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset: tx=%b busy=%b done=%b required 1 0 0", tx, busy, done);
    end
    rst   = 1'b1;
    tx_en = 1'b0;
    check_idle(3 * CPB, "post_reset");
  endtask

  task automatic test_a5();
    send(8'hA5);
    check_frame(8'hA5, "a5");
    exp_done++;
    check_done_count("a5");
  endtask

  task automatic test_ignore();
    send(8'h81);
    fork
      check_frame(8'h81, "ignore");
      begin
        repeat (3 * CPB + 2) @(negedge clk);
        data_in = 8'h3C;
        tx_en   = 1'b1;
        @(negedge clk);
        tx_en   = 1'b0;
      end
    join
    exp_done++;
    check_idle(3 * CPB, "ignore");
    check_done_count("ignore");
  endtask

  task automatic test_reset_mid();
    logic [7:0] b;
    int waited;
    b = 8'($urandom);
    send(b);
    waited = 0;
    while (tx !== 1'b0 && waited < 4 * CPB) begin
      @(negedge clk);
      waited++;
    end
    repeat (4 * CPB + CPB / 2) @(negedge clk);
    checks++;
    if (tx !== b[3] || busy !== 1'b1) begin
      errors++;
      $display("FAIL midreset bit3: tx=%b busy=%b required %b 1", tx, busy, b[3]);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL midreset abort: tx=%b busy=%b done=%b required 1 0 0", tx, busy, done);
    end
    rst = 1'b1;
    check_idle(2 * CPB, "midreset");
    check_done_count("midreset");
    send(8'hFF);
    check_frame(8'hFF, "after_reset");
    exp_done++;
    check_done_count("after_reset");
  endtask

  task automatic test_back_to_back();
    data_in = 8'h00;
    tx_en   = 1'b1;
    @(negedge clk);
    fork
      check_frame(8'h00, "b2b_0");
      begin
        repeat (CPB) @(negedge clk);
        data_in = 8'hFF;
      end
    join
    fork
      check_frame(8'hFF, "b2b_1");
      begin
        repeat (2) @(negedge clk);
        tx_en = 1'b0;
      end
    join
    exp_done += 2;
    check_idle(2 * CPB, "b2b");
    check_done_count("b2b");
  endtask

  task automatic test_random();
    logic [7:0] b;
    for (int n = 0; n < 5; n++) begin
      b = 8'($urandom);
      repeat ($urandom_range(0, 5)) @(negedge clk);
      send(b);
      check_frame(b, $sformatf("rand%0d_%02h", n, b));
      exp_done++;
    end
    check_done_count("random");
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    done_pulses = 0;
    exp_done    = 0;
    rst         = 1'b0;
    tx_en       = 1'b0;
    data_in     = 8'h00;
    @(negedge clk);
    test_reset();
    test_a5();
    test_ignore();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
